// File: rtl/rob_core_pkg.sv
// Shared types, sizes and pointer helper for the reorder buffer.
// ROB_SIZE_WIDTH may be overridden with a `define; ROB_WB_BYPASS_EN is honoured by rob_core and rob_entry_array.
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

package rob_core_pkg;
  localparam int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH;
  localparam int XLEN           = 32;
  localparam int ROB_DEPTH      = 1 << ROB_SIZE_WIDTH;
  localparam int ROB_MAX        = ROB_DEPTH - 1;

  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
  typedef logic [4:0]                reg_id_t;
  typedef logic [XLEN-1:0]           xlen_t;

  localparam rob_id_t ROB_NONE_ID = '0;

  // Everything commit needs to know about the oldest entry.
  typedef struct packed {
    logic    mispredict;
    reg_id_t rd;
    xlen_t   value;
    xlen_t   target;
  } rob_head_t;

  // Id 0 is reserved for "none", so pointers wrap from the top id back to 1.
  function automatic rob_id_t rob_ptr_inc(input rob_id_t p);
    return (p == rob_id_t'(ROB_MAX)) ? rob_id_t'(1) : p + rob_id_t'(1);
  endfunction
endpackage

// File: rtl/rob_core_if.sv
// Issue, writeback, lookup and commit signals between the reorder buffer and its neighbours.
// The slave modport is the reorder buffer; master is the decoder/CDB/register-file side.
interface rob_core_if;
  import rob_core_pkg::*;

  logic    rdy;
  logic    dec_valid;
  reg_id_t dec_rd;
  logic    dec_is_branch;
  logic    rob_full;
  rob_id_t issue_rob_id;
  reg_id_t issue_rd;
  logic    wb_valid;
  rob_id_t wb_rob_id;
  xlen_t   wb_value;
  logic    wb_mispredict;
  xlen_t   wb_target;
  rob_id_t ask_rob_id1;
  rob_id_t ask_rob_id2;
  xlen_t   get_value1;
  xlen_t   get_value2;
  logic    get_ready1;
  logic    get_ready2;
  rob_id_t commit_rob_id;
  reg_id_t commit_rd;
  xlen_t   commit_value;
  logic    flush;
  xlen_t   flush_pc;

  modport slave (
    input  rdy, dec_valid, dec_rd, dec_is_branch,
    input  wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target,
    input  ask_rob_id1, ask_rob_id2,
    output rob_full, issue_rob_id, issue_rd,
    output get_value1, get_value2, get_ready1, get_ready2,
    output commit_rob_id, commit_rd, commit_value, flush, flush_pc
  );

  modport master (
    output rdy, dec_valid, dec_rd, dec_is_branch,
    output wb_valid, wb_rob_id, wb_value, wb_mispredict, wb_target,
    output ask_rob_id1, ask_rob_id2,
    input  rob_full, issue_rob_id, issue_rd,
    input  get_value1, get_value2, get_ready1, get_ready2,
    input  commit_rob_id, commit_rd, commit_value, flush, flush_pc
  );
endinterface

// File: rtl/rob_entry_array.sv
// Per-entry storage of the reorder buffer: allocation, CDB capture, two lookup ports and a head port.
// With ROB_WB_BYPASS_EN defined, lookups and the head port also see the writeback of the current cycle.
module rob_entry_array
  import rob_core_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rdy_i,
  input  logic      flush_clear_i,
  input  logic      alloc_en_i,
  input  rob_id_t   alloc_id_i,
  input  reg_id_t   alloc_rd_i,
  input  logic      alloc_is_branch_i,
  input  logic      wb_valid_i,
  input  rob_id_t   wb_id_i,
  input  xlen_t     wb_value_i,
  input  logic      wb_mispredict_i,
  input  xlen_t     wb_target_i,
  input  logic      retire_en_i,
  input  rob_id_t   head_id_i,
  input  rob_id_t   ask_id1_i,
  input  rob_id_t   ask_id2_i,
  output logic      get_ready1_o,
  output xlen_t     get_value1_o,
  output logic      get_ready2_o,
  output xlen_t     get_value2_o,
  output logic      head_ready_o,
  output rob_head_t head_o
);
  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [ROB_DEPTH-1:0] branch_q;
  logic [ROB_DEPTH-1:0] mispredict_q;
  reg_id_t              rd_q     [ROB_DEPTH];
  xlen_t                value_q  [ROB_DEPTH];
  xlen_t                target_q [ROB_DEPTH];
  logic                 wb_hit;

  // Entry 0 is never allocated, so busy_q[0] stays low and writebacks to id 0 fall away.
  assign wb_hit = wb_valid_i & busy_q[wb_id_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      ready_q <= '0;
    end else if (rdy_i) begin
      if (flush_clear_i) begin
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (wb_hit) ready_q[wb_id_i] <= 1'b1;
        if (retire_en_i) begin
          busy_q[head_id_i]  <= 1'b0;
          ready_q[head_id_i] <= 1'b0;
        end
        if (alloc_en_i) begin
          busy_q[alloc_id_i]  <= 1'b1;
          ready_q[alloc_id_i] <= 1'b0;
        end
      end
    end
  end

  // Payload needs no reset: busy/ready gate every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && rdy_i && !flush_clear_i) begin
      if (wb_hit) begin
        value_q[wb_id_i]      <= wb_value_i;
        mispredict_q[wb_id_i] <= wb_mispredict_i & branch_q[wb_id_i];
        target_q[wb_id_i]     <= wb_target_i;
      end
      if (alloc_en_i) begin
        rd_q[alloc_id_i]     <= alloc_rd_i;
        branch_q[alloc_id_i] <= alloc_is_branch_i;
      end
    end
  end

  always_comb begin
    get_ready1_o = busy_q[ask_id1_i] & ready_q[ask_id1_i];
    get_value1_o = get_ready1_o ? value_q[ask_id1_i] : '0;
    get_ready2_o = busy_q[ask_id2_i] & ready_q[ask_id2_i];
    get_value2_o = get_ready2_o ? value_q[ask_id2_i] : '0;
`ifdef ROB_WB_BYPASS_EN
    if (wb_hit && wb_id_i == ask_id1_i) begin
      get_ready1_o = 1'b1;
      get_value1_o = wb_value_i;
    end
    if (wb_hit && wb_id_i == ask_id2_i) begin
      get_ready2_o = 1'b1;
      get_value2_o = wb_value_i;
    end
`endif
  end

  always_comb begin
    head_ready_o      = busy_q[head_id_i] & ready_q[head_id_i];
    head_o.rd         = rd_q[head_id_i];
    head_o.value      = value_q[head_id_i];
    head_o.mispredict = mispredict_q[head_id_i];
    head_o.target     = target_q[head_id_i];
`ifdef ROB_WB_BYPASS_EN
    // An already-latched result takes precedence over a repeated broadcast.
    if (!head_ready_o && wb_hit && wb_id_i == head_id_i) begin
      head_ready_o      = 1'b1;
      head_o.value      = wb_value_i;
      head_o.mispredict = wb_mispredict_i & branch_q[head_id_i];
      head_o.target     = wb_target_i;
    end
`endif
  end
endmodule

// File: rtl/rob_core.sv
// Reorder buffer top: allocation pointers, occupancy count, in-order commit and mispredict flush.
// ROB_WB_BYPASS_EN (see rob_entry_array) lets commit and lookups use the current-cycle writeback.
module rob_core
  import rob_core_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  rob_core_if.slave bus
);
  rob_id_t   head_q, head_d;
  rob_id_t   tail_q, tail_d;
  rob_id_t   count_q, count_d;
  rob_id_t   commit_id_q, commit_id_d;
  reg_id_t   commit_rd_q, commit_rd_d;
  xlen_t     commit_value_q, commit_value_d;
  logic      flush_q, flush_d;
  xlen_t     flush_pc_q, flush_pc_d;
  logic      full, issue_go, commit_go, flush_go, head_ready;
  rob_head_t head_ent;

  // Full looks only at the registered count, so a commit cannot free a slot for the same edge.
  assign full      = (count_q == rob_id_t'(ROB_MAX));
  assign issue_go  = bus.rdy & bus.dec_valid & ~full & ~flush_q;
  assign commit_go = bus.rdy & head_ready;
  assign flush_go  = commit_go & head_ent.mispredict;

  assign bus.rob_full      = full;
  assign bus.issue_rob_id  = issue_go ? tail_q : ROB_NONE_ID;
  assign bus.issue_rd      = issue_go ? bus.dec_rd : '0;
  assign bus.commit_rob_id = commit_id_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_value  = commit_value_q;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;

  rob_entry_array u_entries (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy_i             (bus.rdy),
    .flush_clear_i     (flush_go),
    .alloc_en_i        (issue_go & ~flush_go),
    .alloc_id_i        (tail_q),
    .alloc_rd_i        (bus.dec_rd),
    .alloc_is_branch_i (bus.dec_is_branch),
    .wb_valid_i        (bus.wb_valid),
    .wb_id_i           (bus.wb_rob_id),
    .wb_value_i        (bus.wb_value),
    .wb_mispredict_i   (bus.wb_mispredict),
    .wb_target_i       (bus.wb_target),
    .retire_en_i       (commit_go),
    .head_id_i         (head_q),
    .ask_id1_i         (bus.ask_rob_id1),
    .ask_id2_i         (bus.ask_rob_id2),
    .get_ready1_o      (bus.get_ready1),
    .get_value1_o      (bus.get_value1),
    .get_ready2_o      (bus.get_ready2),
    .get_value2_o      (bus.get_value2),
    .head_ready_o      (head_ready),
    .head_o            (head_ent)
  );

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_id_d    = ROB_NONE_ID;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;

    if (commit_go) begin
      commit_id_d    = head_q;
      commit_rd_d    = head_ent.rd;
      commit_value_d = head_ent.value;
      head_d         = rob_ptr_inc(head_q);
    end
    if (issue_go) tail_d = rob_ptr_inc(tail_q);

    case ({issue_go, commit_go})
      2'b10:   count_d = count_q + rob_id_t'(1);
      2'b01:   count_d = count_q - rob_id_t'(1);
      default: count_d = count_q;
    endcase

    // A mispredicting commit empties the buffer and restarts allocation just past it.
    if (flush_go) begin
      flush_d    = 1'b1;
      flush_pc_d = head_ent.target;
      head_d     = rob_ptr_inc(head_q);
      tail_d     = rob_ptr_inc(head_q);
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q         <= rob_id_t'(1);
      tail_q         <= rob_id_t'(1);
      count_q        <= '0;
      commit_id_q    <= ROB_NONE_ID;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else if (bus.rdy) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_id_q    <= commit_id_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end
endmodule

// File: tb/tb_rob_core.sv
// Randomized scoreboard bench for rob_core: a program-order queue model predicts issue ids,
// lookups and the commit stream; a separate monitor pops predicted commits and compares them.
module tb_rob_core;
  import rob_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rob_core_if bus();

  rob_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          rd;
    logic [31:0] value;
    bit          ready;
    bit          br;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    time         t;
    int          id;
    int          rd;
    logic [31:0] value;
    bit          flush;
    logic [31:0] pc;
  } exp_t;

  ent_t pq[$];
  exp_t expq[$];
  int   nextId = 1;
  bit   flushPend = 0;
  int   lastCommitId = 0;
  int   asserts = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    asserts++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic int incId(input int p);
    return (p == ROB_MAX) ? 1 : p + 1;
  endfunction

  function automatic int findIdx(input int id);
    foreach (pq[i]) if (pq[i].id == id) return i;
    return -1;
  endfunction

  task automatic expQuery(input int id, output bit r, output logic [31:0] v);
    int k;
    k = findIdx(id);
    r = 0;
    v = '0;
    if (k >= 0 && pq[k].ready) begin
      r = 1;
      v = pq[k].value;
    end
`ifdef ROB_WB_BYPASS_EN
    if (k >= 0 && bus.wb_valid && int'(bus.wb_rob_id) == id) begin
      r = 1;
      v = bus.wb_value;
    end
`endif
  endtask

  // Advances the program-order model across one rising edge using the inputs held on the bus.
  task automatic modelStep();
    ent_t h;
    ent_t n;
    exp_t x;
    bit   doCommit;
    bit   issueOk;
    int   k;
    if (!rst_n || !bus.rdy) return;
    doCommit = 0;
    if (pq.size() > 0) begin
      h = pq[0];
      if (h.ready) doCommit = 1;
`ifdef ROB_WB_BYPASS_EN
      else if (bus.wb_valid && int'(bus.wb_rob_id) == h.id) begin
        doCommit = 1;
        h.value = bus.wb_value;
        h.mis = bus.wb_mispredict & h.br;
        h.tgt = bus.wb_target;
      end
`endif
    end
    issueOk = bus.dec_valid && pq.size() < ROB_MAX && !flushPend;
    flushPend = 0;
    lastCommitId = 0;
    if (doCommit) begin
      x.t = $time; x.id = h.id; x.rd = h.rd; x.value = h.value; x.flush = h.mis; x.pc = h.tgt;
      expq.push_back(x);
      lastCommitId = h.id;
      void'(pq.pop_front());
      if (h.mis) begin
        pq.delete();
        nextId = incId(h.id);
        flushPend = 1;
        return;
      end
    end
    if (bus.wb_valid) begin
      k = findIdx(int'(bus.wb_rob_id));
      if (k >= 0) begin
        pq[k].ready = 1;
        pq[k].value = bus.wb_value;
        pq[k].mis = bus.wb_mispredict & pq[k].br;
        pq[k].tgt = bus.wb_target;
      end
    end
    if (issueOk) begin
      n.id = nextId; n.rd = int'(bus.dec_rd); n.value = '0; n.ready = 0;
      n.br = bus.dec_is_branch; n.mis = 0; n.tgt = '0;
      pq.push_back(n);
      nextId = incId(nextId);
    end
  endtask

  task automatic applyStimulus(input bit dv, input int rd, input bit br,
                               input bit wv, input int wid, input logic [31:0] wval,
                               input bit wmis, input logic [31:0] wtgt,
                               input int a1, input int a2, input bit rdyv);
    int          expIssue;
    bit          r;
    logic [31:0] v;
    @(negedge clk);
    bus.rdy           = rdyv;
    bus.dec_valid     = dv;
    bus.dec_rd        = reg_id_t'(rd);
    bus.dec_is_branch = br;
    bus.wb_valid      = wv;
    bus.wb_rob_id     = rob_id_t'(wid);
    bus.wb_value      = wval;
    bus.wb_mispredict = wmis;
    bus.wb_target     = wtgt;
    bus.ask_rob_id1   = rob_id_t'(a1);
    bus.ask_rob_id2   = rob_id_t'(a2);
    #1;
    expIssue = (dv && rdyv && pq.size() < ROB_MAX && !flushPend) ? nextId : 0;
    checkOutput("issue_rob_id", bus.issue_rob_id, expIssue);
    checkOutput("issue_rd", bus.issue_rd, (expIssue != 0) ? (rd & 31) : 0);
    checkOutput("rob_full", bus.rob_full, pq.size() == ROB_MAX);
    expQuery(a1, r, v);
    checkOutput("get_ready1", bus.get_ready1, r);
    checkOutput("get_value1", bus.get_value1, v);
    expQuery(a2, r, v);
    checkOutput("get_ready2", bus.get_ready2, r);
    checkOutput("get_value2", bus.get_value2, v);
    checkOutput("commit_hold", bus.commit_rob_id, lastCommitId);
    checkOutput("flush_level", bus.flush, flushPend);
    @(posedge clk);
    modelStep();
  endtask

  task automatic issueOne(input int rd, input bit br);
    applyStimulus(1, rd, br, 0, 0, '0, 0, '0, $urandom_range(0, ROB_MAX), $urandom_range(0, ROB_MAX), 1);
  endtask

  task automatic wbOne(input int id, input logic [31:0] val, input bit mis, input logic [31:0] tgt);
    applyStimulus(0, 0, 0, 1, id, val, mis, tgt, id, $urandom_range(0, ROB_MAX), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, '0, 0, '0, $urandom_range(0, ROB_MAX), $urandom_range(0, ROB_MAX), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rdy = 1'b1; bus.dec_valid = 1'b0; bus.dec_rd = '0; bus.dec_is_branch = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rob_id = '0; bus.wb_value = '0; bus.wb_mispredict = 1'b0;
    bus.wb_target = '0; bus.ask_rob_id1 = '0; bus.ask_rob_id2 = '0;
    @(posedge clk);
    pq.delete();
    nextId = 1;
    flushPend = 0;
    lastCommitId = 0;
    @(negedge clk);
    #1;
    checkOutput("reset_commit_id", bus.commit_rob_id, 0);
    checkOutput("reset_commit_rd", bus.commit_rd, 0);
    checkOutput("reset_commit_value", bus.commit_value, 0);
    checkOutput("reset_flush", bus.flush, 0);
    checkOutput("reset_flush_pc", bus.flush_pc, 0);
    checkOutput("reset_rob_full", bus.rob_full, 0);
    rst_n = 1'b1;
  endtask

  task automatic randomCycle();
    int cands[$];
    int k;
    bit wv, wm;
    int wid;
    foreach (pq[i]) if (!pq[i].ready) cands.push_back(i);
    wv = 0; wid = 0; wm = 0;
    if (cands.size() > 0 && $urandom_range(0, 9) < 6) begin
      k = cands[$urandom_range(0, cands.size() - 1)];
      wv = 1;
      wid = pq[k].id;
      wm = pq[k].br && ($urandom_range(0, 3) == 0);
    end else if ($urandom_range(0, 9) == 0) begin
      wv = 1;
      wid = $urandom_range(0, ROB_MAX);
      wm = 1'($urandom_range(0, 1));
    end
    applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 31), $urandom_range(0, 3) == 0,
                  wv, wid, $urandom, wm, $urandom,
                  $urandom_range(0, ROB_MAX), $urandom_range(0, ROB_MAX), $urandom_range(0, 9) != 0);
  endtask

  task automatic drainAll();
    int k;
    for (int n = 0; n < 200 && pq.size() > 0; n++) begin
      k = -1;
      foreach (pq[i]) if (k < 0 && !pq[i].ready) k = i;
      if (k >= 0) wbOne(pq[k].id, $urandom, 0, '0);
      else idle(1);
    end
    idle(2);
  endtask

  // Monitor: whenever the DUT was enabled at an edge, compare the commit it presents with the prediction.
  initial begin
    bit   sRdy, sRst, have;
    time  tEdge;
    exp_t e;
    forever begin
      @(posedge clk);
      sRdy = bus.rdy;
      sRst = rst_n;
      tEdge = $time;
      #1;
      if (sRdy === 1'b1 && sRst === 1'b1) begin
        have = (expq.size() > 0 && expq[0].t == tEdge);
        if (have) begin
          e = expq.pop_front();
          checkOutput("commit_rob_id", bus.commit_rob_id, e.id);
          checkOutput("commit_rd", bus.commit_rd, e.rd);
          checkOutput("commit_value", bus.commit_value, e.value);
          checkOutput("commit_flush", bus.flush, e.flush);
          if (e.flush) checkOutput("flush_pc", bus.flush_pc, e.pc);
        end else begin
          checkOutput("commit_rob_id", bus.commit_rob_id, 0);
          checkOutput("commit_flush", bus.flush, 0);
        end
      end
    end
  end

  initial begin
    int a, b, c, x;
    doReset();

    issueOne(5, 0); issueOne(6, 0); issueOne(7, 0);
    applyStimulus(0, 0, 0, 1, 2, 32'h22, 0, '0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, '0, 0, '0, 2, 1, 1);
    wbOne(1, 32'h11, 0, '0);
    wbOne(3, 32'h33, 0, '0);
    idle(4);

    for (int i = 0; i < 8; i++) issueOne(8 + i, 0);
    wbOne(pq[0].id, 32'h44, 0, '0);
    for (int i = 0; i < 3; i++) issueOne(20 + i, 0);
    drainAll();

    a = nextId; issueOne(1, 0);
    b = nextId; issueOne(2, 1);
    c = nextId; issueOne(3, 0);
    issueOne(4, 0);
    wbOne(b, 32'hB0, 1, 32'h100);
    wbOne(a, 32'hA0, 0, '0);
    issueOne(9, 0); issueOne(10, 0); issueOne(11, 0);
    wbOne(c, 32'hC0, 0, '0);
    idle(2);

    x = nextId; issueOne(12, 0);
    wbOne(x, 32'h55, 0, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 13, 0, 0, 0, '0, 0, '0, x, 0, 0);
    idle(2);

    for (int i = 0; i < 4; i++) issueOne(16 + i, 0);
    doReset();
    issueOne(1, 0);
    checkOutput("post_reset_first_id", bus.commit_rob_id, 0);

    for (int i = 0; i < 600; i++) randomCycle();
    drainAll();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
Reorder buffer for the Tomasulo core. Allocates RoB ids to issued instructions, captures CDB writebacks, and answers the register file's dependency lookups through two combinational query ports. Commits in program order to the register file, and raises a flush on a mispredicted branch. It is the producer side of the register file's commit, issue and value-lookup interface.

Parameters:
ROB_SIZE_WIDTH, `ROB_SIZE_WIDTH (3), id width; ids 1..2^W-1 are usable entries, id 0 means "none".
XLEN, 32, data width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rdy  in  1  global enable; state frozen when low
dec_valid  in  1  decoder issue request
dec_rd  in  5  destination register (0 = none)
dec_is_branch  in  1  entry may mispredict
rob_full  out  1  no free entry (registered-count based)
issue_rob_id  out  W  allocated id this cycle, 0 if no issue (combinational)
issue_rd  out  5  dec_rd passthrough, 0 when issue_rob_id==0
wb_valid  in  1  CDB broadcast
wb_rob_id  in  W  broadcasting entry
wb_value  in  XLEN  result
wb_mispredict  in  1  branch resolved wrong
wb_target  in  XLEN  correct pc
ask_rob_id1/2  in  W  lookup ids
get_value1/2  out  XLEN  entry value (combinational)
get_ready1/2  out  1  entry value valid (combinational)
commit_rob_id  out  W  committed id, 0 = no commit (registered)
commit_rd  out  5  committed rd (registered)
commit_value  out  XLEN  committed value (registered)
flush  out  1  one-cycle mispredict pulse (registered)
flush_pc  out  XLEN  redirect pc

Behaviour:
- Per entry: busy, ready, rd, value, is_branch, mispredict, target. Pointers head/tail range 1..2^W-1; increment wraps 2^W-1 -> 1, never 0. Counter count ranges 0..2^W-1.
- Reset (rst_n low at posedge): head=tail=1, count=0, all busy/ready=0. commit_rob_id=0, commit_rd=0, commit_value=0, flush=0, flush_pc=0. Reset wins over all other activity mid-operation.
- rdy low: no state or output register changes; outputs hold. Consumers sample only when rdy high.
- rob_full = (count == 2^W-1). This is the registered count, so a same-cycle commit does not unblock issue.
- Issue: issue_rob_id = tail when dec_valid & !rob_full & rdy & !flush, else 0. At posedge: entry[tail] busy=1, ready=0, rd, is_branch latched; tail++, count++.
- Writeback: wb_valid & busy[wb_rob_id] -> value, ready=1, mispredict, target latched next edge. Writeback to a non-busy id or to id 0 is ignored.
- Query: get_ready = busy[id] & ready[id]; get_value = value[id] when ready, else 0. id 0 -> ready=0, value=0.
- Commit: if busy[head] & ready[head] at posedge -> commit_rob_id=head, commit_rd=rd, commit_value=value next cycle; busy[head]=0, head++, count--. Otherwise commit_rob_id=0. Latency: writeback edge N -> ready at N -> commit outputs valid after edge N+1. At most one commit per cycle.
- Simultaneous issue+commit: count unchanged. Issue into an entry freed by the same-cycle commit is impossible (the full rule prevents it).
- Mispredict: committing an entry with mispredict=1 also sets flush=1 and flush_pc=target in the same registered cycle. Every entry other than the committed one is cleared at that edge, and head=tail=head+1, count=0. Issue and writeback in that cycle are discarded. flush deasserts the next cycle. Issue is suppressed while flush=1.

Optional Feature:
ROB_WB_BYPASS_EN: when defined, a query whose id equals wb_rob_id with wb_valid high returns get_ready=1 and get_value=wb_value in the same cycle. Commit may also take a head-matching writeback directly, saving one cycle. When undefined, queries and commit see only latched state, with latency as above.

Decomposition:
- Shared package/config: ROB_SIZE_WIDTH, ROB_NONE_ID=0, XLEN, and a pointer-increment helper that skips 0.
- One sub-module, rob_entry_array: per-entry storage, writeback capture and the two read ports. rob_core keeps the pointers, count, commit and flush logic.

Test Plan:
- Issue 3 (rd 5,6,7) -> issue_rob_id 1,2,3. Writeback id 2 = 0x22 -> ask 2 gives ready=1, value 0x22. Ask 1 gives ready=0. No commit yet, because head=1 is not ready.
- Writeback 1 = 0x11, then 3 = 0x33 -> commits in order 1/rd5/0x11, 2/rd6/0x22, 3/rd7/0x33 on consecutive cycles.
- Fill 7 entries -> rob_full=1 and the 8th dec_valid gets issue_rob_id=0. Commit 1 and issue 1 -> new id 1 (wrap 7->1), count stays 7.
- Branch id 2 writeback mispredict target 0x100, ids 3..5 in flight -> commit 2 with flush=1 and flush_pc=0x100. Next cycle count=0. A late writeback to id 4 is ignored.
- rdy low for 3 cycles while head is ready -> commit_rob_id holds, no extra commit. It resumes when rdy returns high.
- rst_n low with 4 busy entries -> all outputs 0. The next issue gets id 1.
